// File: rtl/hello_world_qsys_button_pkg.sv
// Shared types and constants for the push-button debouncer.
// The FSM state encoding lives here so the top and bench can share it.
package hello_world_qsys_button_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        ARM_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        ARM_RELEASE = 2'd3
    } btn_state_e;

    localparam logic BTN_RELEASED_RAW = 1'b1;

endpackage

// File: rtl/hello_world_qsys_sync2.sv
// Two-flop synchronizer for one asynchronous bit.
// Both flops load RESET_VAL while reset_n is low.
module hello_world_qsys_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/hello_world_qsys_button_debounce.sv
// Debounces an active-low push-button and emits press/release strobes.
// Define BUTTON_DEBOUNCE_LONG_PRESS_EN to build the long-press detector.
module hello_world_qsys_button_debounce
    import hello_world_qsys_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button_n,
    output logic button_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic            sync_q;
    btn_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            level_d, press_d, release_d;

    hello_world_qsys_sync2 #(
        .RESET_VAL(BTN_RELEASED_RAW)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (button_n),
        .q      (sync_q)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= RELEASED;
            cnt_q         <= '0;
            button_level  <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            button_level  <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = button_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (sync_q != BTN_RELEASED_RAW) begin
                    state_d = ARM_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            ARM_PRESS: begin
                if (sync_q == BTN_RELEASED_RAW) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (sync_q == BTN_RELEASED_RAW) begin
                    state_d = ARM_RELEASE;
                    cnt_d   = CNT_ONE;
                end
            end
            ARM_RELEASE: begin
                if (sync_q != BTN_RELEASED_RAW) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_PRE = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_ONE = LONG_W'(1);

    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              long_d;

    // Counter only runs while staying in PRESSED; any exit restarts it.
    always_comb begin
        long_cnt_d = '0;
        long_d     = 1'b0;
        if (state_q == PRESSED && state_d == PRESSED) begin
            long_cnt_d = long_cnt_q;
            if (long_cnt_q != LONG_MAX) begin
                long_cnt_d = long_cnt_q + LONG_ONE;
                long_d     = (long_cnt_q == LONG_PRE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            long_cnt_q <= '0;
            long_press <= 1'b0;
        end else begin
            long_cnt_q <= long_cnt_d;
            long_press <= long_d;
        end
    end
`else
    // LONG_CYCLES is legal only when >= 1, so this term is always 0.
    assign long_press = 1'b0 & (LONG_CYCLES < 1);
`endif

endmodule

// File: tb/tb_hello_world_qsys_button_debounce.sv
// Directed bench for the button debouncer, DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
// Outputs are sampled 1 time unit after each rising edge.
module tb_hello_world_qsys_button_debounce;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam logic LP_EN = 1'b1;
`else
    localparam logic LP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic button_n;
    logic button_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    int n_chk  = 0;
    int n_fail = 0;

    hello_world_qsys_button_debounce #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (10)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .button_n     (button_n),
        .button_level (button_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int hits;

    initial begin
        reset_n  = 1'b0;
        button_n = 1'b1;
        tick(3);
        chk("rst_level", 32'(button_level), 0);
        chk("rst_press", 32'(press_pulse), 0);
        chk("rst_release", 32'(release_pulse), 0);
        chk("rst_long", 32'(long_press), 0);
        reset_n = 1'b1;
        tick(3);
        chk("idle_level", 32'(button_level), 0);

        // Clean press: accepted on edge 6
        button_n = 1'b0;
        tick(6);
        chk("press_e5_level", 32'(button_level), 0);
        chk("press_e5_pulse", 32'(press_pulse), 0);
        tick(1);
        chk("press_e6_level", 32'(button_level), 1);
        chk("press_e6_pulse", 32'(press_pulse), 1);
        chk("press_e6_rel", 32'(release_pulse), 0);
        tick(1);
        chk("press_e7_pulse", 32'(press_pulse), 0);
        chk("press_e7_level", 32'(button_level), 1);

        // Long press fires 10 cycles after press_pulse
        tick(8);
        chk("long_early", 32'(long_press), 0);
        tick(1);
        chk("long_fire", 32'(long_press), 32'(LP_EN));
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (long_press) hits++;
        end
        chk("long_once", 32'(hits), 0);

        // Release: accepted on edge 6
        button_n = 1'b1;
        tick(6);
        chk("rel_e5_level", 32'(button_level), 1);
        chk("rel_e5_pulse", 32'(release_pulse), 0);
        tick(1);
        chk("rel_e6_level", 32'(button_level), 0);
        chk("rel_e6_pulse", 32'(release_pulse), 1);
        chk("rel_e6_press", 32'(press_pulse), 0);
        tick(1);
        chk("rel_e7_pulse", 32'(release_pulse), 0);

        // Bounce: low 3, high 1, then low held
        hits = 0;
        button_n = 1'b0;
        tick(3);
        if (press_pulse) hits++;
        button_n = 1'b1;
        tick(1);
        if (press_pulse) hits++;
        button_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (press_pulse || button_level) hits++;
        end
        chk("bounce_quiet", 32'(hits), 0);
        tick(1);
        chk("bounce_pulse", 32'(press_pulse), 1);
        chk("bounce_level", 32'(button_level), 1);
        button_n = 1'b1;
        tick(10);
        chk("bounce_rel_level", 32'(button_level), 0);

        // Reset mid ARM_PRESS at cnt=2, button held through
        button_n = 1'b0;
        tick(4);
        reset_n = 1'b0;
        tick(2);
        chk("midrst_level", 32'(button_level), 0);
        chk("midrst_press", 32'(press_pulse), 0);
        reset_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (press_pulse) hits++;
        end
        chk("postrst_quiet", 32'(hits), 0);
        tick(1);
        chk("postrst_pulse", 32'(press_pulse), 1);
        chk("postrst_level", 32'(button_level), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hello_world_qsys_button_debounce.md
HELLO_WORLD_QSYS_BUTTON_DEBOUNCE -- requirements
Module: hello_world_qsys_button_debounce

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 500000, meaning stable-sample count (10 ms at 50 MHz) required to accept a level change; legal range >= 1.
REQ-002 SHALL provide parameter LONG_CYCLES, default 50000000, meaning pressed duration (1 s at 50 MHz) that triggers long_press; legal range >= 1.
REQ-003 SHALL provide port clk, input, 1, the single clock; all logic is in this domain.
REQ-004 SHALL provide port reset_n, input, 1, synchronous active-low reset, sampled only on rising clk.
REQ-005 SHALL provide port button_n, input, 1, raw asynchronous active-low board push-button.
REQ-006 SHALL provide port button_level, output, 1, debounced active-high pressed level; it drives the button PIO in_port.
REQ-007 SHALL provide port press_pulse, output, 1, one-cycle strobe on each accepted press.
REQ-008 SHALL provide port release_pulse, output, 1, one-cycle strobe on each accepted release.
REQ-009 SHALL provide port long_press, output, 1, one-cycle strobe when a press has lasted LONG_CYCLES.

Function
REQ-010 SHALL pass button_n through a 2-flop synchronizer; the second flop, sync_q, is the only value the FSM uses.
REQ-011 SHALL implement FSM states RELEASED, ARM_PRESS, PRESSED, ARM_RELEASE.
REQ-012 In RELEASED with sync_q=0 -> ARM_PRESS, cnt=1; in PRESSED with sync_q=1 -> ARM_RELEASE, cnt=1.
REQ-013 In ARM_x, when sync_q still differs from the stable level and cnt<DEBOUNCE_CYCLES -> cnt+1.
REQ-014 In ARM_x, when sync_q still differs and cnt==DEBOUNCE_CYCLES -> move to new stable state, cnt=0.
REQ-015 In ARM_x, when sync_q returns to the stable level (bounce) -> return to the previous stable state, cnt=0, no output change.
REQ-016 Latency: with edge 0 = first edge sampling the new button_n level, held stable, button_level SHALL change on edge DEBOUNCE_CYCLES+2.
REQ-017 press_pulse/release_pulse SHALL be registered, high exactly the one cycle button_level first shows the new value; never both high together.
REQ-018 SHALL size cnt as $clog2(DEBOUNCE_CYCLES+1) bits, with no wrap possible.
REQ-019 In PRESSED, a long counter SHALL increment per cycle, saturate at LONG_CYCLES, and assert long_press for one cycle on reaching it (once per press).
REQ-020 The long counter SHALL clear on any exit from PRESSED, including ARM_RELEASE; bouncing back to PRESSED restarts it from 0.

Reset
REQ-021 While reset_n=0: sync flops=1 (released), state=RELEASED, all counters=0, button_level/press_pulse/release_pulse/long_press=0.
REQ-022 Reset mid-ARM SHALL abort the qualification; no pulse is emitted.
REQ-023 A button held through reset release SHALL be qualified normally: press accepted DEBOUNCE_CYCLES+2 edges after the first post-reset edge.

Configuration
REQ-024 Macro BUTTON_DEBOUNCE_LONG_PRESS_EN defined: long counter and long_press logic present per REQ-019/020.
REQ-025 Macro undefined: no long counter is synthesized and long_press is tied 0; all other behaviour is identical.

Structure
REQ-026 Shared package hello_world_qsys_button_pkg SHALL hold the FSM state enum and the constant BTN_RELEASED_RAW=1'b1.
REQ-027 The synchronizer SHALL be sub-module hello_world_qsys_sync2 (parameterized reset value); there are no other sub-modules.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
REQ-028 Clean press: button_n 1->0 held -> button_level=1 and press_pulse=1 for one cycle after edge 6.
REQ-029 Bounce: button_n low 3 cycles, high 1, then low held -> no pulse during the bounce; press accepted 6 edges after the final low.
REQ-030 Release: from pressed, button_n 0->1 held -> button_level=0 and release_pulse=1 for one cycle after edge 6.
REQ-031 Long press (macro on): hold low -> long_press is a single pulse 10 cycles after press_pulse; with the macro off, long_press stays 0 throughout.
REQ-032 Reset mid-ARM_PRESS (reset_n=0 at cnt=2) -> all outputs 0; with the button still held, press_pulse occurs 6 edges after reset release.
